// File: rtl/csr_pkg.sv
// Shared CSR address map, op encodings and helpers for the machine-mode CSR file.
// Consumed by csr_unit and csr_counter64.
package csr_pkg;

    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

    localparam logic [31:0] MISA_DEFAULT     = 32'h4000_0100;
    localparam logic [31:0] XTVEC_ALIGN_MASK = 32'hFFFF_FFFC;

    // funct3[1:0] encodings of the Zicsr instructions
    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    function automatic logic [31:0] csr_apply_op(input csr_op_e op,
                                                 input logic [31:0] old_val,
                                                 input logic [31:0] src);
        logic [31:0] res;
        res = old_val;
        case (op)
            CSR_OP_RW: res = src;
            CSR_OP_RS: res = old_val | src;
            CSR_OP_RC: res = old_val & ~src;
            default:   res = old_val;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with independently writable 32-bit halves.
// A low-half write holds the high half; a high-half write lets the low half count but drops its carry.
module csr_counter64
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wrLo,
    input  logic        wrHi,
    input  logic [31:0] wdata,
    output logic [63:0] q
);

    logic [31:0] lo_inc;

    assign lo_inc = q[31:0] + {31'b0, inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (wrLo) begin
            q[31:0] <= wdata;
        end else if (wrHi) begin
            q <= {wdata, lo_inc};
        end else begin
            q <= q + {63'b0, inc};
        end
    end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: decode, RW/RS/RC write data, trap CSRs, mcycle/minstret.
// Counters exist only when CSR_COUNTERS_EN is defined; otherwise their addresses read 0 and ignore writes.
module csr_unit
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID  = 32'd0,
    parameter logic [31:0] MISA_VAL = MISA_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csrOp,
    input  logic        stall,
    input  logic [2:0]  funct3,
    input  logic [11:0] csrAddr,
    input  logic [4:0]  rs1Field,
    input  logic [31:0] rs1Data,
    input  logic        instRetire,
    output logic [31:0] csrRdata,
    output logic        illegalCsr
);

`ifdef CSR_COUNTERS_EN
    localparam logic CNT_EN = 1'b1;
`else
    localparam logic CNT_EN = 1'b0;
`endif

    csr_op_e     op;
    logic        is_csr;
    logic        write_intent;
    logic        addr_mapped;
    logic        addr_ro;
    logic        wen;
    logic [31:0] src;
    logic [31:0] old_val;
    logic [31:0] wdata;

    logic [31:0] mscratch_q;
    logic [31:0] mtvec_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;

    assign op           = csr_op_e'(funct3[1:0]);
    assign is_csr       = (op != CSR_OP_NONE);
    assign write_intent = (op == CSR_OP_RW) || (rs1Field != 5'd0);
    assign src          = funct3[2] ? {27'b0, rs1Field} : rs1Data;

    always_comb begin
        addr_mapped = 1'b1;
        addr_ro     = 1'b0;
        old_val     = '0;
        case (csrAddr)
            ADDR_MSCRATCH:  old_val = mscratch_q;
            ADDR_MTVEC:     old_val = mtvec_q;
            ADDR_MEPC:      old_val = mepc_q;
            ADDR_MCAUSE:    old_val = mcause_q;
            ADDR_MVENDORID,
            ADDR_MARCHID,
            ADDR_MIMPID:    addr_ro = 1'b1;
            ADDR_MHARTID: begin
                addr_ro = 1'b1;
                old_val = HART_ID;
            end
            ADDR_MISA: begin
                addr_ro = 1'b1;
                old_val = MISA_VAL;
            end
            ADDR_MCYCLE:    old_val = mcycle_q[31:0];
            ADDR_MCYCLEH:   old_val = mcycle_q[63:32];
            ADDR_MINSTRET:  old_val = minstret_q[31:0];
            ADDR_MINSTRETH: old_val = minstret_q[63:32];
            // User aliases are read-only only when the counters really exist
            ADDR_CYCLE: begin
                addr_ro = CNT_EN;
                old_val = mcycle_q[31:0];
            end
            ADDR_CYCLEH: begin
                addr_ro = CNT_EN;
                old_val = mcycle_q[63:32];
            end
            ADDR_INSTRET: begin
                addr_ro = CNT_EN;
                old_val = minstret_q[31:0];
            end
            ADDR_INSTRETH: begin
                addr_ro = CNT_EN;
                old_val = minstret_q[63:32];
            end
            default:        addr_mapped = 1'b0;
        endcase
    end

    assign illegalCsr = !rst && csrOp && is_csr && (!addr_mapped || (addr_ro && write_intent));
    assign csrRdata   = (rst || !is_csr || !addr_mapped) ? 32'd0 : old_val;
    assign wen        = csrOp && !stall && !rst && !illegalCsr && is_csr && write_intent;
    assign wdata      = csr_apply_op(op, old_val, src);

    always_ff @(posedge clk) begin
        if (rst) begin
            mscratch_q <= '0;
            mtvec_q    <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else if (wen) begin
            case (csrAddr)
                ADDR_MSCRATCH: mscratch_q <= wdata;
                ADDR_MTVEC:    mtvec_q    <= wdata & XTVEC_ALIGN_MASK;
                ADDR_MEPC:     mepc_q     <= wdata & XTVEC_ALIGN_MASK;
                ADDR_MCAUSE:   mcause_q   <= wdata;
                default:       ;
            endcase
        end
    end

`ifdef CSR_COUNTERS_EN
    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wrLo  (wen && (csrAddr == ADDR_MCYCLE)),
        .wrHi  (wen && (csrAddr == ADDR_MCYCLEH)),
        .wdata (wdata),
        .q     (mcycle_q)
    );

    // A stalled retire is not counted; a retiring write to minstret still wins inside the counter
    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (instRetire && !stall),
        .wrLo  (wen && (csrAddr == ADDR_MINSTRET)),
        .wrHi  (wen && (csrAddr == ADDR_MINSTRETH)),
        .wdata (wdata),
        .q     (minstret_q)
    );
`else
    logic unused_inst_retire;

    assign mcycle_q           = '0;
    assign minstret_q         = '0;
    assign unused_inst_retire = instRetire;
`endif

endmodule

// File: tb/tb_csr_unit.sv
// Directed bench for csr_unit: each step pushes its expected read/illegal pair to a scoreboard
// that is popped and compared mid-cycle. Counter expectations collapse to 0 without CSR_COUNTERS_EN.
module tb_csr_unit;

`ifdef CSR_COUNTERS_EN
    localparam logic [31:0] CM  = 32'hFFFF_FFFF;
    localparam logic        CEN = 1'b1;
`else
    localparam logic [31:0] CM  = 32'h0;
    localparam logic        CEN = 1'b0;
`endif

    localparam logic [2:0] RW  = 3'b001;
    localparam logic [2:0] RS  = 3'b010;
    localparam logic [2:0] RC  = 3'b011;
    localparam logic [2:0] RCI = 3'b111;
    localparam logic [2:0] RSI = 3'b110;
    localparam logic [2:0] NOP = 3'b000;

    logic        clk;
    logic        rst;
    logic        csrOp;
    logic        stall;
    logic [2:0]  funct3;
    logic [11:0] csrAddr;
    logic [4:0]  rs1Field;
    logic [31:0] rs1Data;
    logic        instRetire;
    logic [31:0] csrRdata;
    logic        illegalCsr;

    typedef struct {
        logic [31:0] rd;
        logic        il;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;
    logic rst_nxt;

    csr_unit dut (
        .clk        (clk),
        .rst        (rst),
        .csrOp      (csrOp),
        .stall      (stall),
        .funct3     (funct3),
        .csrAddr    (csrAddr),
        .rs1Field   (rs1Field),
        .rs1Data    (rs1Data),
        .instRetire (instRetire),
        .csrRdata   (csrRdata),
        .illegalCsr (illegalCsr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out();
        exp_t e;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            e = sb.pop_front();
            vectors++;
            assert (csrRdata === e.rd) else begin
                miscompares++;
                $error("FAIL %s rdata observed=%h expected=%h", e.tag, csrRdata, e.rd);
            end
            assert (illegalCsr === e.il) else begin
                miscompares++;
                $error("FAIL %s illegal observed=%b expected=%b", e.tag, illegalCsr, e.il);
            end
        end
    endtask

    // One cycle: drive after the edge, push expectation, compare on the falling edge
    task automatic step(input logic op_v, input logic [2:0] f3, input logic [11:0] addr,
                        input logic [4:0] rf, input logic [31:0] rdat, input logic st,
                        input logic ret, input logic [31:0] exp_rd, input logic exp_il,
                        input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst        = rst_nxt;
        csrOp      = op_v;
        funct3     = f3;
        csrAddr    = addr;
        rs1Field   = rf;
        rs1Data    = rdat;
        stall      = st;
        instRetire = ret;
        e.rd  = exp_rd;
        e.il  = exp_il;
        e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
        check_out();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        rst_nxt     = 1'b1;
        csrOp       = 1'b0;
        stall       = 1'b0;
        funct3      = NOP;
        csrAddr     = '0;
        rs1Field    = '0;
        rs1Data     = '0;
        instRetire  = 1'b0;

        // reset held two cycles with live instructions
        step(1, RW, 12'h340, 5'd1, 32'h0000_1234, 0, 0, 32'h0, 0, "rst_write");
        step(1, RW, 12'h7C0, 5'd1, 32'h0,         0, 0, 32'h0, 0, "rst_illegal");
        rst_nxt = 1'b0;
        step(1, RS, 12'hB00, 5'd0, 32'h0, 0, 0, 32'h0, 0, "mcycle_first");
        step(1, RS, 12'h340, 5'd0, 32'h0, 0, 0, 32'h0, 0, "mscratch_reset");

        // mscratch RW / RS x0 / RCI / RSI / stalled write
        step(1, RW,  12'h340, 5'd3,  32'hDEAD_BEEF, 0, 0, 32'h0,         0, "mscratch_rw");
        step(1, RS,  12'h340, 5'd0,  32'hFFFF_FFFF, 0, 0, 32'hDEAD_BEEF, 0, "mscratch_rs_x0");
        step(1, RCI, 12'h340, 5'h0F, 32'hFFFF_FFFF, 0, 0, 32'hDEAD_BEEF, 0, "mscratch_rci");
        step(1, RS,  12'h340, 5'd0,  32'h0,         0, 0, 32'hDEAD_BEE0, 0, "mscratch_after_rci");
        step(1, RSI, 12'h340, 5'h10, 32'h0,         0, 0, 32'hDEAD_BEE0, 0, "mscratch_rsi");
        step(1, RW,  12'h340, 5'd3,  32'h0,         1, 0, 32'hDEAD_BEF0, 0, "mscratch_stalled");
        step(1, RS,  12'h340, 5'd0,  32'h0,         0, 0, 32'hDEAD_BEF0, 0, "mscratch_hold");
        step(1, NOP, 12'h340, 5'd3,  32'h0,         0, 0, 32'h0,         0, "f3_zero_read");
        step(1, NOP, 12'h7C0, 5'd3,  32'h0,         0, 0, 32'h0,         0, "f3_zero_unmapped");

        // trap CSRs
        step(1, RW, 12'h305, 5'd3, 32'h8000_0003, 0, 0, 32'h0,         0, "mtvec_rw");
        step(1, RS, 12'h305, 5'd0, 32'h0,         0, 0, 32'h8000_0000, 0, "mtvec_align");
        step(1, RW, 12'h341, 5'd3, 32'h0000_1236, 0, 0, 32'h0,         0, "mepc_rw");
        step(1, RS, 12'h341, 5'd0, 32'h0,         0, 0, 32'h0000_1234, 0, "mepc_align");
        step(1, RW, 12'h342, 5'd3, 32'h8000_000B, 0, 0, 32'h0,         0, "mcause_rw");
        step(1, RC, 12'h342, 5'd3, 32'h0000_000B, 0, 0, 32'h8000_000B, 0, "mcause_rc");
        step(1, RS, 12'h342, 5'd0, 32'h0,         0, 0, 32'h8000_0000, 0, "mcause_after_rc");

        // mcycle carry across halves; the first read is 18 cycles after release
        step(1, RW, 12'hB00, 5'd3, 32'hFFFF_FFFE, 0, 0, 32'd18 & CM,       0, "mcycle_wr_lo");
        step(1, RW, 12'hB80, 5'd3, 32'h0,         0, 0, 32'h0,             0, "mcycleh_wr");
        step(1, RS, 12'hB00, 5'd0, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF & CM, 0, "mcycle_lo_max");
        step(1, RS, 12'hB80, 5'd0, 32'h0,         0, 0, 32'h1 & CM,        0, "mcycleh_carry");
        step(1, RS, 12'hB00, 5'd0, 32'h0,         0, 0, 32'h1 & CM,        0, "mcycle_lo_wrapped");

        // read-only and unmapped addresses
        step(1, RW,  12'hC00, 5'd3, 32'h0, 0, 0, 32'h2 & CM,    CEN, "cycle_ro_write");
        step(1, RS,  12'hC00, 5'd0, 32'h0, 0, 0, 32'h3 & CM,    0,   "cycle_ro_read");
        step(1, RS,  12'hC80, 5'd0, 32'h0, 0, 0, 32'h1 & CM,    0,   "cycleh_read");
        step(1, RW,  12'h7C0, 5'd3, 32'h5, 0, 0, 32'h0,         1,   "unmapped_rw");
        step(1, RS,  12'hF14, 5'd0, 32'h0, 0, 0, 32'h0,         0,   "mhartid_read");
        step(1, RS,  12'h301, 5'd0, 32'h0, 0, 0, 32'h4000_0100, 0,   "misa_read");
        step(1, RW,  12'h301, 5'd0, 32'h0, 0, 0, 32'h4000_0100, 1,   "misa_write");
        step(1, RSI, 12'hF11, 5'd1, 32'h0, 0, 0, 32'h0,         1,   "mvendorid_rsi");
        step(1, RC,  12'hF12, 5'd0, 32'h0, 0, 0, 32'h0,         0,   "marchid_rc_x0");

        // minstret: write beats retire, stall blocks both, 64-bit wrap
        step(1, RW, 12'hB02, 5'd3, 32'h5,         0, 1, 32'h0,             0, "minstret_wr_retire");
        step(1, RS, 12'hB02, 5'd0, 32'h0,         0, 0, 32'h5 & CM,        0, "minstret_is_5");
        step(1, RW, 12'hB02, 5'd3, 32'd99,        1, 1, 32'h5 & CM,        0, "minstret_stalled");
        step(1, RS, 12'hB02, 5'd0, 32'h0,         0, 0, 32'h5 & CM,        0, "minstret_held");
        step(1, RS, 12'hB02, 5'd0, 32'h0,         0, 1, 32'h5 & CM,        0, "minstret_retire");
        step(1, RS, 12'hB02, 5'd0, 32'h0,         0, 0, 32'h6 & CM,        0, "minstret_inc");
        step(1, RW, 12'hB82, 5'd3, 32'hFFFF_FFFF, 0, 0, 32'h0,             0, "minstreth_wr");
        step(1, RW, 12'hB02, 5'd3, 32'hFFFF_FFFF, 0, 0, 32'h6 & CM,        0, "minstret_wr_max");
        step(1, RS, 12'hB82, 5'd0, 32'h0,         0, 1, 32'hFFFF_FFFF & CM, 0, "minstreth_max");
        step(1, RS, 12'hB02, 5'd0, 32'h0,         0, 0, 32'h0,             0, "minstret_wrap_lo");
        step(1, RS, 12'hB82, 5'd0, 32'h0,         0, 0, 32'h0,             0, "minstret_wrap_hi");

        // reset asserted mid-instruction
        rst_nxt = 1'b1;
        step(1, RW, 12'h340, 5'd3, 32'h55, 0, 0, 32'h0, 0, "rst_mid_write");
        rst_nxt = 1'b0;
        step(1, RS, 12'h340, 5'd0, 32'h0, 0, 0, 32'h0,      0, "mscratch_cleared");
        step(1, RS, 12'h305, 5'd0, 32'h0, 0, 0, 32'h0,      0, "mtvec_cleared");
        step(1, RS, 12'hB00, 5'd0, 32'h0, 0, 0, 32'h2 & CM, 0, "mcycle_restart");

        assert (sb.size() == 0) else begin
            miscompares++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
